mem_arbiter_2p: RTL and testbench
=================================

# mem_arbiter_2p

Two-port round-robin arbiter that shares the single SAYAC cache port between the data-access requester (port 0) and the instruction-fetch requester (port 1). It sits between the processor's two memory masters and the cache. It registers the winning request, drives it to the cache, and returns the cache `ready`/`datain` only to the granted requester. A watchdog aborts any access the cache never completes.

## Interface
- `DATA_WIDTH`, 16, data bus width
- `ADR_WIDTH`, 16, address bus width
- `TIMEOUT`, 255, max cycles a granted access may wait for `mem_ready` (1..255, 8-bit counter)

- `clk`  in  1  single clock, all state changes on rising edge
- `rst`  in  1  reset, asynchronous and active-low
- `rd0`, `wr0`  in  1 each  port 0 read/write request
- `address0`  in  ADR_WIDTH  port 0 address
- `wdata0`  in  DATA_WIDTH  port 0 write data
- `rdata0`  out  DATA_WIDTH  port 0 read data
- `ready0`  out  1  port 0 completion
- `rd1`, `wr1`, `address1`, `wdata1`, `rdata1`, `ready1`: same for port 1
- `mem_rd`, `mem_wr`  out  1 each  cache read/write strobe
- `mem_address`  out  ADR_WIDTH  cache address
- `mem_dataout`  out  DATA_WIDTH  cache write data
- `mem_datain`  in  DATA_WIDTH  cache read data
- `mem_ready`  in  1  cache completion
- `timeout`  out  1  one-cycle pulse on watchdog abort

## Operation
- FSM states: IDLE, GRANT0, GRANT1.
- In IDLE, port n is requesting when `rdn | wrn` is high.
  - Only one port requesting: grant it.
  - Both requesting: grant the port not granted last. The `last` pointer resets to 1, so port 0 wins the first tie.
- On grant, at the same edge:
  - register the winner's address into `mem_address` and its write data into `mem_dataout`
  - set `mem_wr = wrn`, `mem_rd = rdn & ~wrn`; write wins if both are high
  - set `last = n`, clear the watchdog counter
- While in GRANTn:
  - `mem_*` outputs stay stable.
  - `readyn = mem_ready` and `rdatan = mem_datain`, both combinational.
  - The non-granted port sees `ready = 0` and `rdata = 0`.
  - Requester input changes are ignored; the request was latched at grant.
- The edge that samples `mem_ready = 1` in GRANTn moves the FSM to IDLE and clears `mem_rd`, `mem_wr`, `mem_address` and `mem_dataout`.
- Requester rule: a requester must drop or replace its request at the first edge after it sees `ready`. IDLE samples at the next edge, so the old request is never re-granted.
- Watchdog: counts cycles in GRANTn. On reaching `TIMEOUT` with `mem_ready` still low:
  - go to IDLE, clear the strobes, pulse `timeout` for one cycle
  - the requester gets no `ready`
  - `last` is kept, so the other port wins the next tie
- `mem_ready` high while in IDLE is ignored.

## Timing
- Reset (`rst` low, asynchronous) forces:
  - state IDLE, `last = 1`, counter 0
  - `mem_rd = mem_wr = 0`, `mem_address = 0`, `mem_dataout = 0`, `timeout = 0`
  - `ready0/1 = 0`, `rdata0/1 = 0`
- Reset release takes effect at the first rising edge with `rst` high.
- Request latency: request visible before edge k → `mem_rd`/`mem_wr` high after edge k.
- Completion: cache raises `mem_ready` after edge j → `readyn` high in the same cycle → strobes low after edge j+1.
- Gap between back-to-back grants: minimum one IDLE cycle.
- Reset mid-access drops the strobes immediately; the access is neither completed nor flagged.
- Request and `mem_ready` at the same edge in IDLE: the request is granted and `mem_ready` is ignored.
- Watchdog count: with `TIMEOUT = T` and no `mem_ready`, the strobes are high for exactly T cycles, and `timeout` is high in the cycle after they fall.

## Test plan
- Single write, port 0: `wr0`, `address0 = 0x0010`, `wdata0 = 0x0751`; cache replies `mem_ready` 3 cycles later.
  - `mem_wr = 1`, `mem_address = 0x0010`, `mem_dataout = 0x0751` one edge after the request.
  - `ready0` pulses with `mem_ready`; `ready1` stays 0.
  - strobes return to 0.
- Read, port 1: `rd1`, `address1 = 0x0012`, `mem_datain = 0x2222`.
  - `rdata1 = 0x2222` while `ready1 = 1`; `rdata0 = 0`.
- Simultaneous requests from reset: `rd0` at 0x0011, `rd1` at 0x0020, both held after completion.
  - Grant order 0, 1, 0, 1.
  - Each grant separated by exactly one IDLE cycle.
- Both `rd0` and `wr0` high → `mem_wr = 1`, `mem_rd = 0`.
  - Requester changes `address0` mid-grant → `mem_address` unchanged.
- `TIMEOUT = 4`, cache never replies.
  - `mem_rd` high for 4 cycles, then `timeout` pulses once and `ready0` never rises.
  - A following port 1 request is granted normally.
- Assert `rst = 0` while GRANT0 is active.
  - All outputs go to 0 asynchronously, without waiting for a clock edge.
  - After release, the first tie goes to port 0.

Source files
------------

// File: rtl/mem_arbiter_2p.sv
// Two-port round-robin arbiter sharing one cache port between data access (port 0)
// and instruction fetch (port 1); a watchdog aborts accesses the cache never completes.
module mem_arbiter_2p #(
    parameter int DATA_WIDTH = 16,
    parameter int ADR_WIDTH  = 16,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd0,
    input  logic                  wr0,
    input  logic [ADR_WIDTH-1:0]  address0,
    input  logic [DATA_WIDTH-1:0] wdata0,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic                  ready0,
    input  logic                  rd1,
    input  logic                  wr1,
    input  logic [ADR_WIDTH-1:0]  address1,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic                  ready1,
    output logic                  mem_rd,
    output logic                  mem_wr,
    output logic [ADR_WIDTH-1:0]  mem_address,
    output logic [DATA_WIDTH-1:0] mem_dataout,
    input  logic [DATA_WIDTH-1:0] mem_datain,
    input  logic                  mem_ready,
    output logic                  timeout
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } state_t;

    // Watchdog counter is cleared at grant, so it expires on the TIMEOUT-th cycle of the grant.
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);

    state_t                state, state_next;
    logic                  last;
    logic [7:0]            wd_cnt;
    logic                  req0, req1;
    logic                  grant0, grant1, done, expire;
    logic                  sel_rd, sel_wr;
    logic [ADR_WIDTH-1:0]  sel_address;
    logic [DATA_WIDTH-1:0] sel_wdata;

    assign req0 = rd0 | wr0;
    assign req1 = rd1 | wr1;

    // NOTE: every signal is given a default before the case, so no path can infer a latch.
    always_comb begin
        state_next = state;
        grant0     = 1'b0;
        grant1     = 1'b0;
        done       = 1'b0;
        expire     = 1'b0;
        unique case (state)
            IDLE: begin
                // last == 1 means port 1 was served most recently, so port 0 wins a tie.
                if (req0 && (!req1 || last)) begin
                    grant0     = 1'b1;
                    state_next = GRANT0;
                end else if (req1) begin
                    grant1     = 1'b1;
                    state_next = GRANT1;
                end
            end
            GRANT0, GRANT1: begin
                if (mem_ready) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end else if (wd_cnt == WD_LAST) begin
                    expire     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Write wins when a requester raises rd and wr together.
    assign sel_rd      = grant1 ? (rd1 & ~wr1) : (rd0 & ~wr0);
    assign sel_wr      = grant1 ? wr1 : wr0;
    assign sel_address = grant1 ? address1 : address0;
    assign sel_wdata   = grant1 ? wdata1 : wdata0;

    assign ready0 = (state == GRANT0) && mem_ready;
    assign ready1 = (state == GRANT1) && mem_ready;
    assign rdata0 = (state == GRANT0) ? mem_datain : '0;
    assign rdata1 = (state == GRANT1) ? mem_datain : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the cache-facing datapath registers are reset too, since they must read 0 after reset.
            last        <= 1'b1;
            wd_cnt      <= '0;
            mem_rd      <= 1'b0;
            mem_wr      <= 1'b0;
            mem_address <= '0;
            mem_dataout <= '0;
            timeout     <= 1'b0;
        end else begin
            timeout <= expire;
            if (grant0 || grant1) begin
                mem_rd      <= sel_rd;
                mem_wr      <= sel_wr;
                mem_address <= sel_address;
                mem_dataout <= sel_wdata;
                last        <= grant1;
                wd_cnt      <= '0;
            end else if (done || expire) begin
                mem_rd      <= 1'b0;
                mem_wr      <= 1'b0;
                mem_address <= '0;
                mem_dataout <= '0;
            end else if (state != IDLE) begin
                wd_cnt <= wd_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter_2p.sv
// Randomized bench for mem_arbiter_2p: a queue-based arbitration model predicts every
// cache transaction; a monitor compares the DUT against those predictions cycle by cycle.
module tb_mem_arbiter_2p;
    localparam int DW = 16;
    localparam int AW = 16;
    localparam int T  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rd0, wr0, rd1, wr1;
    logic [AW-1:0] address0, address1;
    logic [DW-1:0] wdata0, wdata1, rdata0, rdata1;
    logic          ready0, ready1;
    logic          mem_rd, mem_wr, mem_ready, timeout;
    logic [AW-1:0] mem_address;
    logic [DW-1:0] mem_dataout, mem_datain;

    always #5 clk = ~clk;

    mem_arbiter_2p #(.DATA_WIDTH(DW), .ADR_WIDTH(AW), .TIMEOUT(T)) dut (
        .clk(clk), .rst(rst),
        .rd0(rd0), .wr0(wr0), .address0(address0), .wdata0(wdata0), .rdata0(rdata0), .ready0(ready0),
        .rd1(rd1), .wr1(wr1), .address1(address1), .wdata1(wdata1), .rdata1(rdata1), .ready1(ready1),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_address(mem_address), .mem_dataout(mem_dataout),
        .mem_datain(mem_datain), .mem_ready(mem_ready), .timeout(timeout)
    );

    // One requester access; d = strobe cycle in which the cache answers (d > T: never in time).
    typedef struct {logic rd; logic wr; logic [AW-1:0] addr; logic [DW-1:0] data; int d;} acc_t;
    typedef struct {int port; logic mrd; logic mwr; logic [AW-1:0] addr; logic [DW-1:0] data;
                    int len; logic timed_out; int gap;} exp_t;
    typedef struct {int port; int d;} resp_t;

    acc_t  st0[$], st1[$], acc_q0[$], acc_q1[$];
    exp_t  exp_q[$];
    resp_t resp_q[$];

    int    n_vec = 0, n_err = 0;
    bit    mon_en = 1'b0;
    int    last_m = 1;
    int    rsp_n = 0, abandon_port = -1;
    resp_t rcur;
    bit    in_txn = 1'b0;
    exp_t  cur;
    int    n_high = 0, idle_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_acc(input int p, input bit rd, input bit wr, input logic [AW-1:0] addr,
                            input logic [DW-1:0] data, input int d);
        acc_t a;
        a.rd = rd; a.wr = wr; a.addr = addr; a.data = data; a.d = d;
        if (p == 0) st0.push_back(a);
        else        st1.push_back(a);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_rd"}, 32'(mem_rd), 0);
        check({tag, "_mem_wr"}, 32'(mem_wr), 0);
        check({tag, "_mem_address"}, 32'(mem_address), 0);
        check({tag, "_mem_dataout"}, 32'(mem_dataout), 0);
        check({tag, "_timeout"}, 32'(timeout), 0);
        check({tag, "_ready0"}, 32'(ready0), 0);
        check({tag, "_ready1"}, 32'(ready1), 0);
        check({tag, "_rdata0"}, 32'(rdata0), 0);
        check({tag, "_rdata1"}, 32'(rdata1), 0);
    endtask

    // Reference model: requesters present all accesses back to back, so while both queues
    // hold work every arbitration is a tie won by the port not served last.
    task automatic run_round();
        acc_t q0[$], q1[$];
        acc_t a;
        exp_t e;
        resp_t r;
        int w;
        bit first, busy;
        first = 1'b1;
        q0 = st0; q1 = st1;
        while (q0.size() > 0 || q1.size() > 0) begin
            if (q0.size() > 0 && q1.size() > 0) w = (last_m == 1) ? 0 : 1;
            else                                w = (q0.size() > 0) ? 0 : 1;
            if (w == 0) begin a = q0[0]; q0.delete(0); end
            else        begin a = q1[0]; q1.delete(0); end
            e.port = w; e.mwr = a.wr; e.mrd = a.rd & ~a.wr; e.addr = a.addr; e.data = a.data;
            e.timed_out = (a.d > T);
            e.len = e.timed_out ? T : a.d;
            e.gap = first ? -1 : 1;
            exp_q.push_back(e);
            r.port = w; r.d = a.d;
            resp_q.push_back(r);
            last_m = w;
            first = 1'b0;
        end
        acc_q0 = st0; acc_q1 = st1;
        st0.delete(); st1.delete();
        busy = 1'b1;
        for (int c = 0; c < 500 && busy; c++) begin
            @(negedge clk); #2;
            busy = acc_q0.size() != 0 || acc_q1.size() != 0 || exp_q.size() != 0 || in_txn;
        end
        check("round_drained", 32'(busy), 0);
        if (busy) begin
            acc_q0.delete(); acc_q1.delete(); exp_q.delete(); resp_q.delete();
        end
        repeat (2) @(negedge clk);
        #2;
    endtask

    // Requesters and cache: sample at negedge, drive just after posedge.
    initial begin : driver
        logic s_r0, s_r1;
        rd0 = 0; wr0 = 0; rd1 = 0; wr1 = 0;
        address0 = 0; address1 = 0; wdata0 = 0; wdata1 = 0;
        mem_ready = 0; mem_datain = 0;
        forever begin
            @(negedge clk);
            s_r0 = ready0; s_r1 = ready1;
            @(posedge clk); #1;
            if (s_r0 && acc_q0.size() > 0) acc_q0.delete(0);
            if (s_r1 && acc_q1.size() > 0) acc_q1.delete(0);
            if (abandon_port == 0 && acc_q0.size() > 0) acc_q0.delete(0);
            if (abandon_port == 1 && acc_q1.size() > 0) acc_q1.delete(0);
            abandon_port = -1;
            if (acc_q0.size() > 0) begin
                rd0 = acc_q0[0].rd; wr0 = acc_q0[0].wr; address0 = acc_q0[0].addr; wdata0 = acc_q0[0].data;
            end else begin
                rd0 = 0; wr0 = 0; address0 = AW'($urandom); wdata0 = DW'($urandom);
            end
            if (acc_q1.size() > 0) begin
                rd1 = acc_q1[0].rd; wr1 = acc_q1[0].wr; address1 = acc_q1[0].addr; wdata1 = acc_q1[0].data;
            end else begin
                rd1 = 0; wr1 = 0; address1 = AW'($urandom); wdata1 = DW'($urandom);
            end
            // The granted requester scribbles on its address/data mid-grant; the cache must not see it.
            if ((mem_rd || mem_wr) && rsp_n > 0 && $urandom_range(1, 0) == 1) begin
                if (rcur.port == 0) begin address0 = AW'($urandom); wdata0 = DW'($urandom); end
                else                begin address1 = AW'($urandom); wdata1 = DW'($urandom); end
            end
            mem_datain = DW'($urandom);
            if (mem_rd || mem_wr) begin
                if (rsp_n == 0) begin
                    if (resp_q.size() > 0) rcur = resp_q.pop_front();
                    else begin rcur.port = 0; rcur.d = 1; end
                end
                rsp_n++;
                mem_ready = (rsp_n == rcur.d);
                if (rsp_n == T && rcur.d > T) abandon_port = rcur.port;
            end else begin
                rsp_n = 0;
                mem_ready = 1'($urandom_range(1, 0));
            end
        end
    end

    always @(negedge clk) begin
        if (mon_en) begin
            if (mem_rd || mem_wr) begin
                if (!in_txn) begin
                    check("grant_expected", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) cur = exp_q.pop_front();
                    if (cur.gap >= 0) check("grant_gap", 32'(idle_cnt), 32'(cur.gap));
                    in_txn = 1'b1;
                    n_high = 0;
                end
                n_high++;
                check("mem_rd", 32'(mem_rd), 32'(cur.mrd));
                check("mem_wr", 32'(mem_wr), 32'(cur.mwr));
                check("mem_address", 32'(mem_address), 32'(cur.addr));
                check("mem_dataout", 32'(mem_dataout), 32'(cur.data));
                check("timeout_busy", 32'(timeout), 0);
                if (cur.port == 0) begin
                    check("ready0_granted", 32'(ready0), 32'(mem_ready));
                    check("rdata0_granted", 32'(rdata0), 32'(mem_datain));
                    check("ready1_blocked", 32'(ready1), 0);
                    check("rdata1_blocked", 32'(rdata1), 0);
                end else begin
                    check("ready1_granted", 32'(ready1), 32'(mem_ready));
                    check("rdata1_granted", 32'(rdata1), 32'(mem_datain));
                    check("ready0_blocked", 32'(ready0), 0);
                    check("rdata0_blocked", 32'(rdata0), 0);
                end
            end else begin
                if (in_txn) begin
                    check("strobe_cycles", 32'(n_high), 32'(cur.len));
                    check("timeout_pulse", 32'(timeout), 32'(cur.timed_out));
                    in_txn = 1'b0;
                    idle_cnt = 0;
                end else begin
                    check("timeout_idle", 32'(timeout), 0);
                end
                idle_cnt++;
                check("ready0_idle", 32'(ready0), 0);
                check("ready1_idle", 32'(ready1), 0);
                check("rdata0_idle", 32'(rdata0), 0);
                check("rdata1_idle", 32'(rdata1), 0);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin : main
        acc_t  a;
        resp_t r;
        int    cnt0, cnt1, op;
        #1 rst = 1'b0;
        #2 check_all_zero("reset_async");
        repeat (2) @(negedge clk);
        check_all_zero("reset_clocked");
        rst = 1'b1;
        @(negedge clk); #2;
        mon_en = 1'b1;

        push_acc(0, 0, 1, 16'h0010, 16'h0751, 3);
        run_round();
        push_acc(1, 1, 0, 16'h0012, 16'h0000, 2);
        run_round();
        push_acc(0, 1, 1, 16'h0030, 16'h1234, 4);
        run_round();
        push_acc(0, 1, 0, 16'h0040, 16'h0000, T + 3);
        run_round();
        push_acc(1, 1, 0, 16'h0044, 16'h0000, 2);
        run_round();

        // Reset in the middle of a port 0 grant.
        mon_en = 1'b0;
        a.rd = 1; a.wr = 0; a.addr = 16'h0050; a.data = 16'h5555; a.d = 100;
        r.port = 0; r.d = 100;
        resp_q.push_back(r);
        acc_q0.push_back(a);
        for (int c = 0; c < 20 && !(mem_rd || mem_wr); c++) @(negedge clk);
        check("rst_test_granted", 32'(mem_rd), 1);
        #2 rst = 1'b0;
        #1 check_all_zero("reset_mid_grant");
        acc_q0.delete(); acc_q1.delete(); resp_q.delete(); exp_q.delete();
        abandon_port = -1; in_txn = 1'b0; last_m = 1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); #2;
        mon_en = 1'b1;

        // Both ports request from reset and keep requesting: grants alternate 0,1,0,1.
        push_acc(0, 1, 0, 16'h0011, 16'h0000, 2);
        push_acc(0, 1, 0, 16'h0011, 16'h0000, 3);
        push_acc(1, 1, 0, 16'h0020, 16'h0000, 1);
        push_acc(1, 1, 0, 16'h0020, 16'h0000, 2);
        run_round();

        for (int i = 0; i < 40; i++) begin
            cnt0 = $urandom_range(3, 0);
            cnt1 = $urandom_range(3, 0);
            if (cnt0 == 0 && cnt1 == 0) cnt0 = 1;
            for (int k = 0; k < cnt0; k++) begin
                op = $urandom_range(3, 1);
                push_acc(0, op[0], op[1], AW'($urandom), DW'($urandom), $urandom_range(T + 2, 1));
            end
            for (int k = 0; k < cnt1; k++) begin
                op = $urandom_range(3, 1);
                push_acc(1, op[0], op[1], AW'($urandom), DW'($urandom), $urandom_range(T + 2, 1));
            end
            run_round();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
